// File: rtl/ins_mem_loader.sv
// Streams 2*WORD_WIDTH-bit instructions from a host word stream into instruction memory port A.
// Optional LOADER_CHECKSUM_EN: a trailing XOR checksum word is checked after the last instruction.
module ins_mem_loader #(
    parameter int unsigned INS_ADDR_WIDTH = 8,
    parameter int unsigned INS_WIDTH      = 64,
    parameter int unsigned WORD_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_start,
    input  logic [INS_ADDR_WIDTH:0]   load_len,
    input  logic [WORD_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      ins_we,
    output logic [INS_ADDR_WIDTH-1:0] ins_addr,
    output logic [INS_WIDTH-1:0]      ins_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    localparam int unsigned LEN_W = INS_ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << INS_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_FIN   = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [LEN_W-1:0]      count_q, count_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [WORD_WIDTH-1:0] lo_q, lo_d;
`ifdef LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum_q, csum_d;
`endif

    logic                      s_ready_q, s_ready_d;
    logic                      ins_we_q, ins_we_d;
    logic [INS_ADDR_WIDTH-1:0] ins_addr_q, ins_addr_d;
    logic [INS_WIDTH-1:0]      ins_wdata_q, ins_wdata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic xfer;
    logic start_acc;
    logic len_ok;
    logic last;

    assign xfer      = s_valid & s_ready_q;
    assign start_acc = load_start & ((state_q == S_IDLE) | (state_q == S_FIN));
    assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
    assign last      = (count_q + LEN_W'(1)) == len_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            len_q   <= '0;
            lo_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        lo_d    = lo_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_FIN: begin
                if (load_start) begin
                    if (len_ok) begin
                        state_d = S_LO;
                        count_d = '0;
                        len_d   = load_len;
`ifdef LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = s_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    state_d = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ s_data ^ lo_q;
`endif
                end
            end
            S_WRITE: begin
                count_d = count_q + LEN_W'(1);
                if (last) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    state_d = S_LO;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_d = S_FIN;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output next values, decoded from the upcoming state so outputs stay in step with it
    always_comb begin
        s_ready_d   = (state_d == S_LO) || (state_d == S_HI);
        busy_d      = (state_d == S_LO) || (state_d == S_HI) || (state_d == S_WRITE);
        done_d      = (state_d == S_FIN);
        ins_we_d    = (state_d == S_WRITE);
        ins_addr_d  = ins_addr_q;
        ins_wdata_d = ins_wdata_q;
        error_d     = error_q;
`ifdef LOADER_CHECKSUM_EN
        if (state_d == S_CSUM) begin
            s_ready_d = 1'b1;
            busy_d    = 1'b1;
        end
        if ((state_q == S_CSUM) && xfer) error_d = (s_data != csum_q);
`endif
        if ((state_q == S_HI) && xfer) begin
            ins_addr_d  = count_q[INS_ADDR_WIDTH-1:0];
            ins_wdata_d = INS_WIDTH'({s_data, lo_q});
        end
        if (start_acc) error_d = ~len_ok;
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready_q   <= 1'b0;
            ins_we_q    <= 1'b0;
            ins_addr_q  <= '0;
            ins_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            s_ready_q   <= s_ready_d;
            ins_we_q    <= ins_we_d;
            ins_addr_q  <= ins_addr_d;
            ins_wdata_q <= ins_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign ins_we    = ins_we_q;
    assign ins_addr  = ins_addr_q;
    assign ins_wdata = ins_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed bench for ins_mem_loader: stream source model, write monitor, per-scenario tasks.
module tb_ins_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic [8:0]  load_len = '0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        ins_we;
    logic [7:0]  ins_addr;
    logic [63:0] ins_wdata;
    logic        busy;
    logic        done;
    logic        error;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] src_q[$];
    bit          src_rand = 1'b0;
    logic [7:0]  wr_addr[$];
    logic [63:0] wr_data[$];
    int unsigned wr_nobusy = 0;

    ins_mem_loader #(
        .INS_ADDR_WIDTH(8),
        .INS_WIDTH(64),
        .WORD_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_start(load_start),
        .load_len(load_len),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .ins_we(ins_we),
        .ins_addr(ins_addr),
        .ins_wdata(ins_wdata),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Host stream source: pops on handshake, presents next word #1 after the edge
    always begin
        @(posedge clk);
        if (s_valid && s_ready && src_q.size() > 0) src_q.delete(0);
        #1;
        if (src_q.size() > 0 && (!src_rand || $urandom_range(0, 1) == 1)) begin
            s_valid = 1'b1;
            s_data  = src_q[0];
        end else begin
            s_valid = 1'b0;
            s_data  = '0;
        end
    end

    // Memory write monitor
    always @(posedge clk) begin
        if (ins_we) begin
            wr_addr.push_back(ins_addr);
            wr_data.push_back(ins_wdata);
            if (!busy) wr_nobusy++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int unsigned len);
        load_start = 1'b1;
        load_len   = 9'(len);
        step();
        load_start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_nobusy = 0;
    endtask

    function automatic logic [63:0] exp_ins(input int unsigned base, input int unsigned i);
        return {32'(base + 2 * i + 1), 32'(base + 2 * i)};
    endfunction

    task automatic push_prog(input int unsigned n, input int unsigned base);
        logic [31:0] cs;
        logic [31:0] lo;
        logic [31:0] hi;
        cs = '0;
        for (int i = 0; i < int'(n); i++) begin
            lo = 32'(base + 2 * i);
            hi = 32'(base + 2 * i + 1);
            src_q.push_back(lo);
            src_q.push_back(hi);
            cs = cs ^ lo ^ hi;
        end
`ifdef LOADER_CHECKSUM_EN
        src_q.push_back(cs);
`endif
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if ({s_ready, ins_we, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: {s_ready,we,busy,done,error}=%b expected 00000",
                     {s_ready, ins_we, busy, done, error});
        end
        checks++;
        if (ins_addr !== 8'h0 || ins_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h expected 0", ins_addr, ins_wdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int unsigned extra;
`ifdef LOADER_CHECKSUM_EN
        extra = 1;
`else
        extra = 0;
`endif
        clear_log();
        push_prog(2, 1);
        step();
        do_start(2);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: busy=%b done=%b s_ready=%b expected 1 0 1", busy, done, s_ready);
        end
        repeat (5 + extra) step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_done: done=%b expected 0", done);
        end
        step();
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b error=%b busy=%b s_ready=%b expected 1 0 0 0",
                     done, error, busy, s_ready);
        end
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL basic_count: writes=%0d expected 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== 64'h0000000200000001) begin
                errors++;
                $display("FAIL basic_w0: addr=%0d data=%h expected 0 0000000200000001", wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 8'd1 || wr_data[1] !== 64'h0000000400000003) begin
                errors++;
                $display("FAIL basic_w1: addr=%0d data=%h expected 1 0000000400000003", wr_addr[1], wr_data[1]);
            end
        end
    endtask

    task automatic test_bad_len(input int unsigned len);
        clear_log();
        do_start(len);
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badlen_%0d: done=%b error=%b busy=%b expected 1 1 0", len, done, error, busy);
        end
        repeat (3) step();
        checks++;
        if (wr_addr.size() != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL badlen_%0d_hold: writes=%0d done=%b expected 0 1", len, wr_addr.size(), done);
        end
    endtask

    task automatic test_full();
        int unsigned bad;
        clear_log();
        src_rand = 1'b1;
        push_prog(256, 0);
        do_start(256);
        wait_done("full", 5000);
        src_rand = 1'b0;
        checks++;
        if (wr_addr.size() != 256) begin
            errors++;
            $display("FAIL full_count: writes=%0d expected 256", wr_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp_ins(0, i)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL full_order: %0d bad writes expected 0", bad);
            end
        end
        checks++;
        if (wr_nobusy != 0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL full_busy: writes_without_busy=%0d busy=%b error=%b expected 0 0 0",
                     wr_nobusy, busy, error);
        end
        checks++;
        if (src_q.size() != 0) begin
            errors++;
            $display("FAIL full_consumed: words_left=%0d expected 0", src_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int unsigned n;
        clear_log();
        push_prog(10, 100);
        do_start(10);
        n = 0;
        while (!(ins_we === 1'b1 && ins_addr === 8'd5) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (!(ins_we === 1'b1 && ins_addr === 8'd5)) begin
            errors++;
            $display("FAIL rstmid_reach: we=%b addr=%0d expected 1 5", ins_we, ins_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, ins_we, busy, done, error} !== 5'b0 || ins_addr !== 8'h0 || ins_wdata !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: flags=%b addr=%h wdata=%h expected all 0",
                     {s_ready, ins_we, busy, done, error}, ins_addr, ins_wdata);
        end
        step();
        checks++;
        if (wr_addr.size() != 5) begin
            errors++;
            $display("FAIL rstmid_writes: writes=%0d expected 5", wr_addr.size());
        end
        rst = 1'b0;
        src_q.delete();
        clear_log();
        push_prog(2, 7);
        do_start(2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_first_start: busy=%b expected 1", busy);
        end
        wait_done("rstmid", 100);
        checks++;
        if (wr_addr.size() != 2 || error !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_reload: writes=%0d error=%b expected 2 0", wr_addr.size(), error);
        end else begin
            checks++;
            if (wr_addr[0] !== 8'd0 || wr_data[0] !== exp_ins(7, 0) ||
                wr_addr[1] !== 8'd1 || wr_data[1] !== exp_ins(7, 1)) begin
                errors++;
                $display("FAIL rstmid_data: a0=%0d d0=%h a1=%0d d1=%h expected 0 %h 1 %h",
                         wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], exp_ins(7, 0), exp_ins(7, 1));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int unsigned bad;
        clear_log();
        push_prog(3, 50);
        do_start(3);
        for (int k = 0; k < 4; k++) begin
            step();
            load_start = 1'b1;
            load_len   = 9'd1;
            step();
            load_start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_state: busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done("busy_ignore", 100);
        checks++;
        if (wr_addr.size() != 3 || error !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_count: writes=%0d error=%b expected 3 0", wr_addr.size(), error);
        end else begin
            bad = 0;
            for (int i = 0; i < 3; i++)
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp_ins(50, i)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL busy_ignore_data: %0d bad writes expected 0", bad);
            end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log();
        src_q.push_back(32'hA5A5A5A5);
        src_q.push_back(32'h0F0F0F0F);
        src_q.push_back(32'hAAAAAAAA);
        do_start(1);
        wait_done("csum_ok", 50);
        checks++;
        if (error !== 1'b0 || wr_data.size() != 1 || wr_data[0] !== 64'h0F0F0F0FA5A5A5A5) begin
            errors++;
            $display("FAIL csum_ok: error=%b writes=%0d expected 0 1", error, wr_data.size());
        end
        src_q.push_back(32'hA5A5A5A5);
        src_q.push_back(32'h0F0F0F0F);
        src_q.push_back(32'h00000000);
        do_start(1);
        wait_done("csum_bad", 50);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad: error=%b expected 1", error);
        end
    endtask
`else
    task automatic test_checksum();
        clear_log();
        src_q.push_back(32'hA5A5A5A5);
        src_q.push_back(32'h0F0F0F0F);
        src_q.push_back(32'hAAAAAAAA);
        do_start(1);
        wait_done("nocsum", 50);
        repeat (3) step();
        checks++;
        if (error !== 1'b0 || s_ready !== 1'b0 || src_q.size() != 1 || wr_data.size() != 1) begin
            errors++;
            $display("FAIL nocsum: error=%b s_ready=%b words_left=%0d writes=%0d expected 0 0 1 1",
                     error, s_ready, src_q.size(), wr_data.size());
        end
        src_q.delete();
        step();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_bad_len(0);
        test_bad_len(257);
        test_full();
        test_reset_mid();
        test_start_while_busy();
        test_checksum();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
